// File: rtl/hdsiso_pkg.sv
// Shared types and helpers for the hdsiso_lanes multi-lane SISO shift register.
// Optional running parity is enabled by defining HDSISO_PARITY_EN.
package hdsiso_pkg;

  typedef enum logic [1:0] {
    MODE_INDEP  = 2'd0,
    MODE_CONCAT = 2'd1,
    MODE_ROTATE = 2'd2,
    MODE_CLEAR  = 2'd3
  } hdsiso_mode_t;

  // Output stage index for a requested tap; oversized taps clamp to the last stage.
  function automatic int eff_tap(input int sel, input int depth);
    return (sel > depth - 1) ? depth - 1 : sel;
  endfunction

endpackage

// File: rtl/hdsiso_lane.sv
// One lane of hdsiso_lanes: DEPTH-stage shift register, stage-0 input mux, tap mux.
// Running parity flop is present only when HDSISO_PARITY_EN is defined.
module hdsiso_lane
  import hdsiso_pkg::*;
#(
  parameter int DEPTH = 64,
  parameter int SEL_W = $clog2(DEPTH)
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             shift,
  input  hdsiso_mode_t     mode,
  input  logic [SEL_W-1:0] tap_idx,
  input  logic             din_ext,
  input  logic             din_chain,
  output logic             dout,
  output logic             parity
);

  logic [DEPTH-1:0] stage_q, stage_d;
  logic             in_bit;

  assign dout = stage_q[tap_idx];

  always_comb begin
    // NOTE: defaults first so every path assigns each variable; no latch can be inferred.
    stage_d = stage_q;
    in_bit  = 1'b0;
    case (mode)
      MODE_INDEP:  in_bit = din_ext;
      MODE_CONCAT: in_bit = din_chain;
      MODE_ROTATE: in_bit = dout;
      default:     in_bit = 1'b0;
    endcase
    if (shift) begin
      stage_d = (mode == MODE_CLEAR) ? '0 : {stage_q[DEPTH-2:0], in_bit};
    end
  end

  always_ff @(posedge clk) begin
    // NOTE: the stage array is reset, unlike a plain data RAM, because dout must read 0 after reset.
    if (!rst_n) stage_q <= '0;
    else        stage_q <= stage_d;
  end

`ifdef HDSISO_PARITY_EN
  logic parity_q, parity_d;

  always_comb begin
    parity_d = parity_q;
    if (shift) parity_d = (mode == MODE_CLEAR) ? 1'b0 : (parity_q ^ dout);
  end

  always_ff @(posedge clk) begin
    if (!rst_n) parity_q <= 1'b0;
    else        parity_q <= parity_d;
  end

  assign parity = parity_q;
`else
  assign parity = 1'b0;
`endif

endmodule

// File: rtl/hdsiso_lanes.sv
// Multi-lane serial-in serial-out shift register with run-time tap, concat/rotate/clear
// modes and a fill/primed tracker. Define HDSISO_PARITY_EN for per-lane running parity.
module hdsiso_lanes
  import hdsiso_pkg::*;
#(
  parameter int LANES = 8,
  parameter int DEPTH = 64,
  parameter int SEL_W = $clog2(DEPTH),
  parameter int CNT_W = $clog2(LANES * DEPTH + 1)
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             ena,
  input  logic             shift_en,
  input  logic [1:0]       mode,
  input  logic [SEL_W-1:0] tap_sel,
  input  logic [LANES-1:0] din,
  output logic [LANES-1:0] dout,
  output logic [CNT_W-1:0] fill,
  output logic             primed,
  output logic [LANES-1:0] parity
);

  localparam logic [CNT_W-1:0] FILL_MAX = CNT_W'(LANES * DEPTH);

  hdsiso_mode_t     mode_e;
  logic             shift;
  logic [SEL_W-1:0] tap_idx;
  logic [LANES-1:0] chain_in;
  logic [CNT_W-1:0] fill_q, fill_d;
  logic [CNT_W-1:0] len, need;

  assign mode_e  = hdsiso_mode_t'(mode);
  assign shift   = ena & shift_en;
  assign tap_idx = SEL_W'(eff_tap(int'(tap_sel), DEPTH));

  // Lane 0 chains from din[0]; every other lane chains from its neighbour's tap.
  always_comb begin
    chain_in = '0;
    chain_in[0] = din[0];
    for (int l = 1; l < LANES; l++) chain_in[l] = dout[l-1];
  end

  for (genvar l = 0; l < LANES; l++) begin : g_lane
    hdsiso_lane #(
      .DEPTH(DEPTH),
      .SEL_W(SEL_W)
    ) u_lane (
      .clk      (clk),
      .rst_n    (rst_n),
      .shift    (shift),
      .mode     (mode_e),
      .tap_idx  (tap_idx),
      .din_ext  (din[l]),
      .din_chain(chain_in[l]),
      .dout     (dout[l]),
      .parity   (parity[l])
    );
  end

  always_comb begin
    fill_d = fill_q;
    if (shift) begin
      case (mode_e)
        MODE_INDEP, MODE_CONCAT: if (fill_q != FILL_MAX) fill_d = fill_q + CNT_W'(1);
        MODE_CLEAR:              fill_d = '0;
        default:                 fill_d = fill_q;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) fill_q <= '0;
    else        fill_q <= fill_d;
  end

  // Concatenated lanes form one LANES*L long chain, so priming needs that many shifts.
  always_comb begin
    len    = CNT_W'(tap_idx) + CNT_W'(1);
    need   = (mode_e == MODE_CONCAT) ? len * CNT_W'(LANES) : len;
    primed = (fill_q >= need);
  end

  assign fill = fill_q;

endmodule

// File: tb/tb_hdsiso_lanes.sv
// Self-checking bench for hdsiso_lanes: directed scenarios plus randomized traffic
// compared against a lane-array reference model; a small DEPTH=5 instance covers clamping.
module tb_hdsiso_lanes;
  localparam int LANES    = 8;
  localparam int DEPTH    = 64;
  localparam int SEL_W    = 6;
  localparam int CNT_W    = 10;
  localparam int FILL_MAX = LANES * DEPTH;

  logic             clk = 1'b0;
  logic             rst_n = 1'b0;
  logic             ena = 1'b0;
  logic             shift_en = 1'b0;
  logic [1:0]       mode = 2'd0;
  logic [SEL_W-1:0] tap_sel = '0;
  logic [LANES-1:0] din = '0;
  logic [LANES-1:0] dout;
  logic [CNT_W-1:0] fill;
  logic             primed;
  logic [LANES-1:0] parity;

  logic       s_ena = 1'b0;
  logic       s_shift_en = 1'b0;
  logic [1:0] s_mode = 2'd0;
  logic [2:0] s_tap = '0;
  logic [1:0] s_din = '0;
  logic [1:0] s_dout;
  logic [3:0] s_fill;
  logic       s_primed;
  logic [1:0] s_parity;

  int checks = 0;
  int errors = 0;

  bit               m_stage[LANES][DEPTH];
  int               m_fill;
  logic [LANES-1:0] m_par;

  hdsiso_lanes #(.LANES(LANES), .DEPTH(DEPTH)) dut (
    .clk(clk), .rst_n(rst_n), .ena(ena), .shift_en(shift_en), .mode(mode),
    .tap_sel(tap_sel), .din(din), .dout(dout), .fill(fill), .primed(primed),
    .parity(parity)
  );

  hdsiso_lanes #(.LANES(2), .DEPTH(5)) dut_small (
    .clk(clk), .rst_n(rst_n), .ena(s_ena), .shift_en(s_shift_en), .mode(s_mode),
    .tap_sel(s_tap), .din(s_din), .dout(s_dout), .fill(s_fill), .primed(s_primed),
    .parity(s_parity)
  );

  always #5 clk = ~clk;

  // ---------------- reference model ----------------
  function automatic int eff_len();
    int t;
    t = int'(tap_sel);
    return ((t > DEPTH - 1) ? DEPTH - 1 : t) + 1;
  endfunction

  function automatic logic [LANES-1:0] exp_dout();
    logic [LANES-1:0] r;
    int L;
    L = eff_len();
    for (int l = 0; l < LANES; l++) r[l] = m_stage[l][L-1];
    return r;
  endfunction

  function automatic logic exp_primed();
    int L;
    L = eff_len();
    return (mode == 2'd1) ? (m_fill >= LANES * L) : (m_fill >= L);
  endfunction

  function automatic logic [LANES-1:0] exp_parity();
`ifdef HDSISO_PARITY_EN
    return m_par;
`else
    return '0;
`endif
  endfunction

  // Apply one clock edge to the model using the inputs present just before it.
  function automatic void model_edge();
    logic [LANES-1:0] old;
    bit in_bit;
    if (!rst_n) begin
      for (int l = 0; l < LANES; l++) for (int k = 0; k < DEPTH; k++) m_stage[l][k] = 1'b0;
      m_fill = 0;
      m_par  = '0;
    end else if (ena && shift_en) begin
      old = exp_dout();
      if (mode == 2'd3) begin
        for (int l = 0; l < LANES; l++) for (int k = 0; k < DEPTH; k++) m_stage[l][k] = 1'b0;
        m_fill = 0;
        m_par  = '0;
      end else begin
        for (int l = 0; l < LANES; l++) begin
          if (mode == 2'd0)      in_bit = din[l];
          else if (mode == 2'd1) in_bit = (l == 0) ? din[0] : old[l-1];
          else                   in_bit = old[l];
          for (int k = DEPTH - 1; k > 0; k--) m_stage[l][k] = m_stage[l][k-1];
          m_stage[l][0] = in_bit;
          if (old[l]) m_par[l] = ~m_par[l];
        end
        if (mode != 2'd2 && m_fill < FILL_MAX) m_fill = m_fill + 1;
      end
    end
  endfunction

  task automatic step();
    model_edge();
    @(posedge clk);
    #1;
  endtask

  task automatic reset_dut();
    rst_n = 1'b0;
    shift_en = 1'b0;
    step();
    rst_n = 1'b1;
  endtask

  // ---------------- scenarios ----------------
  task automatic test_reset();
    rst_n = 1'b1; ena = 1'b1; shift_en = 1'b1; mode = 2'd0; tap_sel = 6'd5;
    repeat (6) begin din = LANES'($urandom); step(); end
    rst_n = 1'b0; din = LANES'($urandom); step();
    rst_n = 1'b1; shift_en = 1'b0;
    checks++; if (dout !== 8'h00) begin errors++; $display("FAIL reset_dout: got %h want 00", dout); end
    checks++; if (fill !== '0) begin errors++; $display("FAIL reset_fill: got %0d want 0", fill); end
    checks++; if (primed !== 1'b0) begin errors++; $display("FAIL reset_primed: got %b want 0", primed); end
    checks++; if (parity !== 8'h00) begin errors++; $display("FAIL reset_parity: got %h want 00", parity); end
    shift_en = 1'b1;
    repeat (4) begin din = LANES'($urandom); step(); end
    shift_en = 1'b0;
    rst_n = 1'b0; #2; rst_n = 1'b1;
    step();
    checks++; if (fill !== CNT_W'(4)) begin errors++; $display("FAIL reset_glitch_fill: got %0d want 4", fill); end
    checks++; if (dout !== exp_dout()) begin errors++; $display("FAIL reset_glitch_dout: got %h want %h", dout, exp_dout()); end
  endtask

  task automatic test_indep();
    reset_dut();
    mode = 2'd0; tap_sel = 6'd7; ena = 1'b1; shift_en = 1'b1;
    for (int s = 1; s <= 8; s++) begin
      din = (s == 1) ? 8'hA5 : 8'h00;
      step();
      checks++;
      if (dout !== ((s == 8) ? 8'hA5 : 8'h00)) begin
        errors++; $display("FAIL indep_dout shift %0d: got %h want %h", s, dout, (s == 8) ? 8'hA5 : 8'h00);
      end
      checks++;
      if (primed !== (s == 8)) begin errors++; $display("FAIL indep_primed shift %0d: got %b", s, primed); end
    end
    shift_en = 1'b0;
    checks++; if (fill !== CNT_W'(8)) begin errors++; $display("FAIL indep_fill: got %0d want 8", fill); end
    tap_sel = 6'd3; #1;
    checks++; if (dout !== 8'h00) begin errors++; $display("FAIL indep_tap3_dout: got %h want 00", dout); end
    checks++; if (primed !== 1'b1) begin errors++; $display("FAIL indep_tap3_primed: got %b want 1", primed); end
  endtask

  task automatic test_concat();
    logic [LANES-1:0] r;
    reset_dut();
    mode = 2'd1; tap_sel = 6'd3; ena = 1'b1; shift_en = 1'b1;
    for (int s = 1; s <= 32; s++) begin
      r = LANES'($urandom);
      din = {r[LANES-1:1], (s == 1)};
      step();
      checks++;
      if (dout[7] !== (s == 32)) begin errors++; $display("FAIL concat_dout7 shift %0d: got %b", s, dout[7]); end
      checks++;
      if (primed !== (s >= 32)) begin errors++; $display("FAIL concat_primed shift %0d: got %b", s, primed); end
      checks++;
      if (dout !== exp_dout()) begin errors++; $display("FAIL concat_model shift %0d: got %h want %h", s, dout, exp_dout()); end
    end
  endtask

  task automatic test_rotate();
    logic [7:0] want;
    reset_dut();
    mode = 2'd0; tap_sel = 6'd7; ena = 1'b1; shift_en = 1'b1;
    for (int k = 0; k < 8; k++) begin
      for (int l = 0; l < LANES; l++) din[l] = (7 - k == l);
      step();
    end
    shift_en = 1'b0;
    for (int t = 0; t < 8; t++) begin
      tap_sel = SEL_W'(t); #1;
      want = 8'h01 << t;
      checks++; if (dout !== want) begin errors++; $display("FAIL rotate_load tap %0d: got %h want %h", t, dout, want); end
    end
    @(posedge clk); #1;
    mode = 2'd2; tap_sel = 6'd7; din = 8'hFF; shift_en = 1'b1;
    repeat (8) begin
      step();
      checks++; if (dout !== exp_dout()) begin errors++; $display("FAIL rotate_model: got %h want %h", dout, exp_dout()); end
    end
    shift_en = 1'b0;
    for (int t = 0; t < 8; t++) begin
      tap_sel = SEL_W'(t); #1;
      want = 8'h01 << t;
      checks++; if (dout !== want) begin errors++; $display("FAIL rotate_after tap %0d: got %h want %h", t, dout, want); end
    end
    @(posedge clk); #1;
    checks++; if (fill !== CNT_W'(8)) begin errors++; $display("FAIL rotate_fill: got %0d want 8", fill); end
    tap_sel = 6'd7;
    repeat (3) step();
    checks++; if (dout !== 8'h80) begin errors++; $display("FAIL rotate_hold: got %h want 80", dout); end
  endtask

  task automatic test_clear();
    reset_dut();
    mode = 2'd0; tap_sel = 6'd2; ena = 1'b1; shift_en = 1'b1;
    repeat (5) begin din = LANES'($urandom) | 8'h01; step(); end
    mode = 2'd3; step();
    checks++; if (dout !== 8'h00) begin errors++; $display("FAIL clear_dout: got %h want 00", dout); end
    checks++; if (fill !== '0) begin errors++; $display("FAIL clear_fill: got %0d want 0", fill); end
    checks++; if (primed !== 1'b0) begin errors++; $display("FAIL clear_primed: got %b want 0", primed); end
    tap_sel = 6'd0; #1;
    checks++; if (dout !== 8'h00) begin errors++; $display("FAIL clear_tap0: got %h want 00", dout); end
    mode = 2'd0; tap_sel = 6'd2;
    repeat (3) begin din = LANES'($urandom); step(); end
    ena = 1'b0;
    repeat (10) begin din = LANES'($urandom); step(); end
    checks++; if (fill !== CNT_W'(3)) begin errors++; $display("FAIL ena_hold_fill: got %0d want 3", fill); end
    checks++; if (dout !== exp_dout()) begin errors++; $display("FAIL ena_hold_dout: got %h want %h", dout, exp_dout()); end
    ena = 1'b1;
  endtask

  task automatic test_parity();
    bit pat[4] = '{1'b1, 1'b1, 1'b0, 1'b1};
    bit par_want[4] = '{1'b0, 1'b1, 1'b0, 1'b0};
    logic want;
    logic [LANES-1:0] r;
    reset_dut();
    mode = 2'd0; tap_sel = 6'd0; ena = 1'b1; shift_en = 1'b1;
    for (int s = 0; s < 4; s++) begin
      r = LANES'($urandom);
      din = {r[LANES-1:1], pat[s]};
      step();
`ifdef HDSISO_PARITY_EN
      want = par_want[s];
`else
      want = 1'b0;
`endif
      checks++; if (parity[0] !== want) begin errors++; $display("FAIL parity0 shift %0d: got %b want %b", s + 1, parity[0], want); end
      checks++; if (parity !== exp_parity()) begin errors++; $display("FAIL parity_vec shift %0d: got %h want %h", s + 1, parity, exp_parity()); end
    end
  endtask

  task automatic test_random();
    int r;
    for (int i = 0; i < 400; i++) begin
      r = $urandom_range(0, 19);
      mode = (r < 8) ? 2'd0 : (r < 13) ? 2'd1 : (r < 19) ? 2'd2 : 2'd3;
      tap_sel  = SEL_W'($urandom);
      ena      = ($urandom_range(0, 7) != 0);
      shift_en = ($urandom_range(0, 3) != 0);
      din      = LANES'($urandom);
      rst_n    = ($urandom_range(0, 99) != 0);
      #1;
      checks++; if (dout !== exp_dout()) begin errors++; $display("FAIL rand_comb_dout %0d: got %h want %h", i, dout, exp_dout()); end
      checks++; if (primed !== exp_primed()) begin errors++; $display("FAIL rand_comb_primed %0d: got %b want %b", i, primed, exp_primed()); end
      step();
      checks++; if (dout !== exp_dout()) begin errors++; $display("FAIL rand_dout %0d: got %h want %h", i, dout, exp_dout()); end
      checks++; if (fill !== CNT_W'(m_fill)) begin errors++; $display("FAIL rand_fill %0d: got %0d want %0d", i, fill, m_fill); end
      checks++; if (parity !== exp_parity()) begin errors++; $display("FAIL rand_parity %0d: got %h want %h", i, parity, exp_parity()); end
    end
    rst_n = 1'b1;
  endtask

  task automatic test_small_clamp();
    ena = 1'b0;
    s_ena = 1'b1; s_shift_en = 1'b1; s_mode = 2'd0; s_tap = 3'd7;
    for (int s = 1; s <= 5; s++) begin
      s_din = (s == 1) ? 2'b11 : 2'b00;
      step();
      if (s == 4) begin
        checks++; if (s_dout !== 2'b00) begin errors++; $display("FAIL clamp_early: got %b want 00", s_dout); end
      end
    end
    s_shift_en = 1'b0;
    checks++; if (s_primed !== 1'b1) begin errors++; $display("FAIL clamp_primed: got %b want 1", s_primed); end
    for (int t = 3; t < 8; t++) begin
      s_tap = 3'(t); #1;
      checks++;
      if (s_dout !== ((t >= 4) ? 2'b11 : 2'b00)) begin errors++; $display("FAIL clamp_tap %0d: got %b", t, s_dout); end
    end
    @(posedge clk); #1;
    s_tap = 3'd7; s_shift_en = 1'b1;
    repeat (7) step();
    checks++; if (s_fill !== 4'd10) begin errors++; $display("FAIL fill_saturate: got %0d want 10", s_fill); end
    s_shift_en = 1'b0; s_mode = 2'd1; #1;
    checks++; if (s_primed !== 1'b1) begin errors++; $display("FAIL clamp_concat_primed: got %b want 1", s_primed); end
    s_ena = 1'b0;
  endtask

  initial begin
    m_fill = 0;
    m_par  = '0;
    for (int l = 0; l < LANES; l++) for (int k = 0; k < DEPTH; k++) m_stage[l][k] = 1'b0;
    rst_n = 1'b0;
    step();
    step();
    test_reset();
    test_indep();
    test_concat();
    test_rotate();
    test_clear();
    test_parity();
    test_random();
    test_small_clamp();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
